// File: rtl/scr1_mprf_wb_pkg.sv
// Shared definitions for the EXU-side MPRF writeback controller.
//   SCR1_XLEN / SCR1_RF_SIZE / SCR1_AW / SCR1_LL_MAX : default geometry.
//   type_scr1_wb_req_s : one writeback request {vd, rd, data}.
//   scr1_wb_commits()  : true when a request actually writes the MPRF (x0 never does).
package scr1_mprf_wb_pkg;

  localparam int unsigned SCR1_XLEN    = 32;
  localparam int unsigned SCR1_RF_SIZE = 32;
  localparam int unsigned SCR1_AW      = $clog2(SCR1_RF_SIZE);
  localparam int unsigned SCR1_LL_MAX  = 2;

  typedef struct packed {
    logic                 vd;
    logic [SCR1_AW-1:0]   rd;
    logic [SCR1_XLEN-1:0] data;
  } type_scr1_wb_req_s;

  // A valid request to x0 is consumed but never reaches the write port.
  function automatic logic scr1_wb_commits(input type_scr1_wb_req_s r);
    return r.vd && (r.rd != '0);
  endfunction

endpackage

// File: rtl/scr1_pipe_mprf_sb.sv
// Long-latency destination scoreboard and outstanding-op counter.
//   clk, rst_n         : clock, async active-low reset
//   ll_issue_vd_i/rd_i : LL op issued (accepted only while ll_issue_rdy_o)
//   ll_wb_vd_i/rd_i    : LL result returning; clears its scoreboard bit
//   ll_kill_i          : flush, scoreboard and counter are zero next cycle
//   ll_issue_rdy_o     : room for another outstanding LL op
//   sb_o               : one pending bit per register, bit 0 always 0
module scr1_pipe_mprf_sb
  import scr1_mprf_wb_pkg::*;
#(
  parameter int unsigned RF_SIZE = SCR1_RF_SIZE,
  parameter int unsigned AW      = SCR1_AW,
  parameter int unsigned LL_MAX  = SCR1_LL_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ll_issue_vd_i,
  input  logic [AW-1:0]      ll_issue_rd_i,
  input  logic               ll_kill_i,
  input  logic               ll_wb_vd_i,
  input  logic [AW-1:0]      ll_wb_rd_i,
  output logic               ll_issue_rdy_o,
  output logic [RF_SIZE-1:0] sb_o
);

  localparam int unsigned CW = $clog2(LL_MAX + 1);

  logic [RF_SIZE-1:0] sb_q, sb_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_after_wb;
  logic               wb_dec, issue_fire;

  // Never decrement below zero, so the counter cannot wrap.
  assign wb_dec       = ll_wb_vd_i && (cnt_q != '0);
  assign cnt_after_wb = cnt_q - CW'(wb_dec);

  // A result retiring this cycle frees its slot for a same-cycle issue,
  // which lets a full queue keep streaming at one op per cycle.
  assign ll_issue_rdy_o = (cnt_after_wb < CW'(LL_MAX));
  assign issue_fire     = ll_issue_vd_i && ll_issue_rdy_o;

  always_comb begin
    sb_d = sb_q;
    if (ll_wb_vd_i) sb_d[ll_wb_rd_i] = 1'b0;
    // Set is applied after clear so a same-index set+clear leaves it set.
    if (issue_fire) sb_d[ll_issue_rd_i] = 1'b1;
    sb_d[0] = 1'b0;
    if (ll_kill_i) sb_d = '0;
  end

  always_comb begin
    cnt_d = cnt_after_wb + CW'(issue_fire);
    if (ll_kill_i) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign sb_o = sb_q;

endmodule

// File: rtl/scr1_pipe_mprf_wb_ctrl.sv
// EXU-side MPRF controller: owns the single write port and both read ports.
//   idu_rs1/rs2/rd_*      : decode operand/destination usage
//   hazard_stall_o        : decode must hold (RAW on pending LL, WAW on pending LL)
//   exu2mprf_rs*_addr_o   : read addresses, straight from decode
//   mprf2exu_rs*_data_i   : async MPRF read data
//   rs*_data_o            : operands after x0 / write / skid forwarding
//   ll_issue_*, ll_kill_i : long-latency issue tracking (scoreboard sub-module)
//   ll_wb_*               : long-latency result, always accepted
//   alu_wb_*              : 1-cycle ALU/CSR result with ready
//   exu2mprf_w_req_o/rd_addr_o/rd_data_o : MPRF write port (combinational)
module scr1_pipe_mprf_wb_ctrl
  import scr1_mprf_wb_pkg::*;
#(
  parameter int unsigned XLEN    = SCR1_XLEN,
  parameter int unsigned RF_SIZE = SCR1_RF_SIZE,
  parameter int unsigned AW      = SCR1_AW,
  parameter int unsigned LL_MAX  = SCR1_LL_MAX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   idu_rs1_addr_i,
  input  logic            idu_rs1_req_i,
  input  logic [AW-1:0]   idu_rs2_addr_i,
  input  logic            idu_rs2_req_i,
  input  logic [AW-1:0]   idu_rd_addr_i,
  input  logic            idu_rd_req_i,
  output logic            hazard_stall_o,
  output logic [AW-1:0]   exu2mprf_rs1_addr_o,
  output logic [AW-1:0]   exu2mprf_rs2_addr_o,
  input  logic [XLEN-1:0] mprf2exu_rs1_data_i,
  input  logic [XLEN-1:0] mprf2exu_rs2_data_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            ll_issue_vd_i,
  input  logic [AW-1:0]   ll_issue_rd_i,
  output logic            ll_issue_rdy_o,
  input  logic            ll_kill_i,
  input  logic            ll_wb_vd_i,
  input  logic [AW-1:0]   ll_wb_rd_i,
  input  logic [XLEN-1:0] ll_wb_data_i,
  input  logic            alu_wb_vd_i,
  input  logic [AW-1:0]   alu_wb_rd_i,
  input  logic [XLEN-1:0] alu_wb_data_i,
  output logic            alu_wb_rdy_o,
  output logic            exu2mprf_w_req_o,
  output logic [AW-1:0]   exu2mprf_rd_addr_o,
  output logic [XLEN-1:0] exu2mprf_rd_data_o
);

  // The request struct carries package-width fields; XLEN/AW stay at the
  // package defaults for this build.
  type_scr1_wb_req_s ll_req, alu_req, skid_q, skid_d, wr;
  logic [RF_SIZE-1:0] sb;
  logic               ll_wb_eff, skid_pop, alu_fire, alu_to_skid;
  logic               ll_hit_rs1, ll_hit_rs2;

  scr1_pipe_mprf_sb #(
    .RF_SIZE (RF_SIZE),
    .AW      (AW),
    .LL_MAX  (LL_MAX)
  ) u_sb (
    .clk            (clk),
    .rst_n          (rst_n),
    .ll_issue_vd_i  (ll_issue_vd_i),
    .ll_issue_rd_i  (ll_issue_rd_i),
    .ll_kill_i      (ll_kill_i),
    .ll_wb_vd_i     (ll_wb_vd_i),
    .ll_wb_rd_i     (ll_wb_rd_i),
    .ll_issue_rdy_o (ll_issue_rdy_o),
    .sb_o           (sb)
  );

  // A result arriving in the kill cycle belongs to a flushed op.
  assign ll_wb_eff = ll_wb_vd_i & ~ll_kill_i;
  assign ll_req    = {ll_wb_eff, ll_wb_rd_i, ll_wb_data_i};
  assign alu_req   = {alu_wb_vd_i, alu_wb_rd_i, alu_wb_data_i};

  // Port priority: LL > skid > ALU.
  always_comb begin
    if (ll_wb_eff)      wr = ll_req;
    else if (skid_q.vd) wr = skid_q;
    else                wr = alu_req;
  end

  // Skid drains whenever LL does not own the port, so ALU stays ready
  // unless the skid is full and blocked by an LL write.
  assign skid_pop     = skid_q.vd & ~ll_wb_eff;
  assign alu_wb_rdy_o = ~skid_q.vd | skid_pop;
  assign alu_fire     = alu_wb_vd_i & alu_wb_rdy_o;
  assign alu_to_skid  = alu_fire & (ll_wb_eff | skid_q.vd);

  always_comb begin
    skid_d = skid_q;
    if (skid_pop)    skid_d.vd = 1'b0;
    if (alu_to_skid) skid_d    = alu_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skid_q <= '0;
    else        skid_q <= skid_d;
  end

  assign exu2mprf_w_req_o   = scr1_wb_commits(wr);
  assign exu2mprf_rd_addr_o = wr.rd;
  assign exu2mprf_rd_data_o = wr.data;

  assign exu2mprf_rs1_addr_o = idu_rs1_addr_i;
  assign exu2mprf_rs2_addr_o = idu_rs2_addr_i;

  // The MPRF read is async and the write lands on the edge, so the
  // in-flight write and the parked skid entry must bypass the array.
  function automatic logic [XLEN-1:0] fwd(
    input logic [AW-1:0]     a,
    input logic [XLEN-1:0]   m,
    input type_scr1_wb_req_s w,
    input type_scr1_wb_req_s s
  );
    if (a == '0)                return '0;
    else if (w.vd && w.rd == a) return w.data;
    else if (s.vd && s.rd == a) return s.data;
    else                        return m;
  endfunction

  assign rs1_data_o = fwd(idu_rs1_addr_i, mprf2exu_rs1_data_i, wr, skid_q);
  assign rs2_data_o = fwd(idu_rs2_addr_i, mprf2exu_rs2_data_i, wr, skid_q);

  // A pending source resolves in the cycle its LL result is forwarded.
  assign ll_hit_rs1 = ll_wb_eff && (ll_wb_rd_i == idu_rs1_addr_i);
  assign ll_hit_rs2 = ll_wb_eff && (ll_wb_rd_i == idu_rs2_addr_i);

  // WAW term keeps the ALU from ever writing a register with an LL write pending.
  assign hazard_stall_o = (idu_rs1_req_i & sb[idu_rs1_addr_i] & ~ll_hit_rs1) |
                          (idu_rs2_req_i & sb[idu_rs2_addr_i] & ~ll_hit_rs2) |
                          (idu_rd_req_i  & sb[idu_rd_addr_i]);

  a_ll_wb_pending: assert property (@(posedge clk) disable iff (!rst_n)
    (ll_wb_vd_i && ll_wb_rd_i != '0) |-> sb[ll_wb_rd_i]);

  a_w_req_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(exu2mprf_w_req_o));

  a_ll_issue_rdy: assert property (@(posedge clk) disable iff (!rst_n)
    ll_issue_vd_i |-> ll_issue_rdy_o);

endmodule

// File: tb/tb_scr1_pipe_mprf_wb_ctrl.sv
module tb_scr1_pipe_mprf_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_a, rs2_a, rd_a;
  logic        rs1_r, rs2_r, rd_r;
  logic        stall;
  logic [4:0]  rs1_ao, rs2_ao;
  logic [31:0] m_rs1, m_rs2, rs1_d, rs2_d;
  logic        iss_vd, iss_rdy, kill;
  logic [4:0]  iss_rd;
  logic        llw_vd;
  logic [4:0]  llw_rd;
  logic [31:0] llw_d;
  logic        alu_vd, alu_rdy;
  logic [4:0]  alu_rd;
  logic [31:0] alu_d;
  logic        w_req;
  logic [4:0]  w_rd;
  logic [31:0] w_d;

  typedef struct { logic [4:0] rd; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  scr1_pipe_mprf_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .idu_rs1_addr_i(rs1_a), .idu_rs1_req_i(rs1_r),
    .idu_rs2_addr_i(rs2_a), .idu_rs2_req_i(rs2_r),
    .idu_rd_addr_i(rd_a), .idu_rd_req_i(rd_r),
    .hazard_stall_o(stall),
    .exu2mprf_rs1_addr_o(rs1_ao), .exu2mprf_rs2_addr_o(rs2_ao),
    .mprf2exu_rs1_data_i(m_rs1), .mprf2exu_rs2_data_i(m_rs2),
    .rs1_data_o(rs1_d), .rs2_data_o(rs2_d),
    .ll_issue_vd_i(iss_vd), .ll_issue_rd_i(iss_rd), .ll_issue_rdy_o(iss_rdy),
    .ll_kill_i(kill),
    .ll_wb_vd_i(llw_vd), .ll_wb_rd_i(llw_rd), .ll_wb_data_i(llw_d),
    .alu_wb_vd_i(alu_vd), .alu_wb_rd_i(alu_rd), .alu_wb_data_i(alu_d),
    .alu_wb_rdy_o(alu_rdy),
    .exu2mprf_w_req_o(w_req), .exu2mprf_rd_addr_o(w_rd), .exu2mprf_rd_data_o(w_d)
  );

  always #5 clk = ~clk;

  // Write-port monitor: every MPRF write must match the oldest expected one.
  always @(negedge clk) begin
    if (w_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got rd=%0d data=%h, none expected", w_rd, w_d);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (w_rd !== e.rd || w_d !== e.data) begin
          errors++;
          $display("FAIL wr_port got rd=%0d data=%h, expected rd=%0d data=%h",
                   w_rd, w_d, e.rd, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd = rd; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    rs1_a = '0; rs2_a = '0; rd_a = '0; rs1_r = 0; rs2_r = 0; rd_r = 0;
    m_rs1 = '0; m_rs2 = '0;
    iss_vd = 0; iss_rd = '0; kill = 0;
    llw_vd = 0; llw_rd = '0; llw_d = '0;
    alu_vd = 0; alu_rd = '0; alu_d = '0;
  endtask

  // Inputs change 1 time unit after the active edge; checks sample at negedge.
  task automatic nxt();
    @(posedge clk); #1; idle();
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; idle();
    smp();
    chk("rst_w_req", {31'b0, w_req}, 32'd0);
    chk("rst_alu_rdy", {31'b0, alu_rdy}, 32'd1);
    chk("rst_ll_rdy", {31'b0, iss_rdy}, 32'd1);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1 rst_n = 1;

    // ALU x5 and LL x6 collide: LL first, ALU parked in skid.
    nxt(); iss_vd = 1; iss_rd = 5'd6; smp();
    nxt(); alu_vd = 1; alu_rd = 5'd5; alu_d = 32'h11;
    llw_vd = 1; llw_rd = 5'd6; llw_d = 32'h22; expect_wr(5'd6, 32'h22); smp();
    chk("collide_alu_rdy", {31'b0, alu_rdy}, 32'd1);
    nxt(); alu_vd = 1; alu_rd = 5'd7; alu_d = 32'h33; expect_wr(5'd5, 32'h11); smp();
    chk("skid_drain_alu_rdy", {31'b0, alu_rdy}, 32'd1);
    nxt(); expect_wr(5'd7, 32'h33); smp();

    // Skid full and blocked by an LL write -> ALU back-pressured.
    nxt(); iss_vd = 1; iss_rd = 5'd8; smp();
    nxt(); alu_vd = 1; alu_rd = 5'd12; alu_d = 32'h44;
    llw_vd = 1; llw_rd = 5'd8; llw_d = 32'h55; iss_vd = 1; iss_rd = 5'd13;
    expect_wr(5'd8, 32'h55); smp();
    chk("issue_with_wb_rdy", {31'b0, iss_rdy}, 32'd1);
    nxt(); llw_vd = 1; llw_rd = 5'd13; llw_d = 32'h66; alu_vd = 1; alu_rd = 5'd14; alu_d = 32'h77;
    rs1_a = 5'd12; rs2_a = 5'd13; rs2_r = 1; m_rs1 = 32'hAAAA; m_rs2 = 32'hBBBB;
    expect_wr(5'd13, 32'h66); smp();
    chk("skid_blocked_alu_rdy", {31'b0, alu_rdy}, 32'd0);
    chk("fwd_skid_rs1", rs1_d, 32'h44);
    chk("fwd_wr_rs2", rs2_d, 32'h66);
    chk("wb_clears_stall", {31'b0, stall}, 32'd0);
    chk("rs1_addr_pass", {27'b0, rs1_ao}, 32'd12);
    chk("rs2_addr_pass", {27'b0, rs2_ao}, 32'd13);
    nxt(); alu_vd = 1; alu_rd = 5'd14; alu_d = 32'h77; expect_wr(5'd12, 32'h44); smp();
    chk("retry_alu_rdy", {31'b0, alu_rdy}, 32'd1);
    nxt(); expect_wr(5'd14, 32'h77); smp();

    // RAW on pending LL x9.
    nxt(); iss_vd = 1; iss_rd = 5'd9; smp();
    nxt(); rs1_a = 5'd9; rs1_r = 1; smp();
    chk("raw_stall_c0", {31'b0, stall}, 32'd1);
    nxt(); rs1_a = 5'd9; rs1_r = 1; smp();
    chk("raw_stall_c1", {31'b0, stall}, 32'd1);
    nxt(); rs1_a = 5'd9; rs1_r = 1; m_rs1 = 32'h1234;
    llw_vd = 1; llw_rd = 5'd9; llw_d = 32'hDEAD; expect_wr(5'd9, 32'hDEAD); smp();
    chk("raw_wb_stall", {31'b0, stall}, 32'd0);
    chk("raw_wb_fwd", rs1_d, 32'hDEAD);

    // Counter limit and simultaneous wb+issue.
    nxt(); iss_vd = 1; iss_rd = 5'd1; smp();
    chk("cnt0_rdy", {31'b0, iss_rdy}, 32'd1);
    nxt(); iss_vd = 1; iss_rd = 5'd2; smp();
    chk("cnt1_rdy", {31'b0, iss_rdy}, 32'd1);
    nxt(); rd_a = 5'd1; rd_r = 1; smp();
    chk("cnt2_rdy", {31'b0, iss_rdy}, 32'd0);
    chk("waw_stall", {31'b0, stall}, 32'd1);
    nxt(); llw_vd = 1; llw_rd = 5'd1; llw_d = 32'hA1; iss_vd = 1; iss_rd = 5'd3;
    expect_wr(5'd1, 32'hA1); smp();
    chk("wb_issue_rdy", {31'b0, iss_rdy}, 32'd1);
    nxt(); rs1_a = 5'd1; rs1_r = 1; smp();
    chk("cnt_stays2_rdy", {31'b0, iss_rdy}, 32'd0);
    chk("sb_x1_clear", {31'b0, stall}, 32'd0);
    nxt(); rs1_a = 5'd2; rs1_r = 1; smp();
    chk("sb_x2_set", {31'b0, stall}, 32'd1);
    nxt(); rs2_a = 5'd3; rs2_r = 1; smp();
    chk("sb_x3_set", {31'b0, stall}, 32'd1);
    nxt(); kill = 1; smp();
    nxt(); rs1_a = 5'd2; rs1_r = 1; rs2_a = 5'd3; rs2_r = 1; smp();
    chk("kill_sb_clear", {31'b0, stall}, 32'd0);
    chk("kill_cnt_rdy", {31'b0, iss_rdy}, 32'd1);

    // Kill coincident with wb: result dropped.
    nxt(); iss_vd = 1; iss_rd = 5'd4; smp();
    nxt(); kill = 1; llw_vd = 1; llw_rd = 5'd4; llw_d = 32'hBAD; smp();
    chk("kill_wb_no_write", {31'b0, w_req}, 32'd0);
    nxt(); rs1_a = 5'd4; rs1_r = 1; rd_a = 5'd4; rd_r = 1; iss_vd = 1; iss_rd = 5'd10; smp();
    chk("kill_x4_no_stall", {31'b0, stall}, 32'd0);
    chk("kill_cnt0_rdy", {31'b0, iss_rdy}, 32'd1);
    nxt(); iss_vd = 1; iss_rd = 5'd11; smp();
    chk("post_kill_cnt1_rdy", {31'b0, iss_rdy}, 32'd1);
    nxt(); smp();
    chk("post_kill_cnt2_rdy", {31'b0, iss_rdy}, 32'd0);
    nxt(); kill = 1; smp();

    // x0 write and x0 read.
    nxt(); alu_vd = 1; alu_rd = 5'd0; alu_d = 32'h99;
    rs1_a = 5'd0; rs2_a = 5'd0; m_rs1 = 32'h5555_5555; m_rs2 = 32'hFFFF_FFFF; smp();
    chk("x0_w_req", {31'b0, w_req}, 32'd0);
    chk("x0_alu_rdy", {31'b0, alu_rdy}, 32'd1);
    chk("x0_rs2", rs2_d, 32'h0);
    chk("x0_rs1", rs1_d, 32'h0);

    // Direct ALU write with forwarding.
    nxt(); alu_vd = 1; alu_rd = 5'd3; alu_d = 32'h1234_5678; rs1_a = 5'd3; m_rs1 = 32'h0;
    expect_wr(5'd3, 32'h1234_5678); smp();
    chk("alu_fwd_rs1", rs1_d, 32'h1234_5678);

    // Reset mid-run with skid full.
    nxt(); iss_vd = 1; iss_rd = 5'd20; smp();
    nxt(); alu_vd = 1; alu_rd = 5'd21; alu_d = 32'h5;
    llw_vd = 1; llw_rd = 5'd20; llw_d = 32'h6; expect_wr(5'd20, 32'h6); smp();
    nxt(); rst_n = 0; smp();
    chk("midrst_w_req", {31'b0, w_req}, 32'd0);
    chk("midrst_alu_rdy", {31'b0, alu_rdy}, 32'd1);
    @(posedge clk); #1 rst_n = 1;
    nxt(); rs1_a = 5'd21; m_rs1 = 32'h777; smp();
    chk("postrst_w_req", {31'b0, w_req}, 32'd0);
    chk("postrst_alu_rdy", {31'b0, alu_rdy}, 32'd1);
    chk("postrst_skid_empty", rs1_d, 32'h777);
    chk("postrst_ll_rdy", {31'b0, iss_rdy}, 32'd1);

    nxt(); smp();
    nxt(); smp();
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
